// File: rtl/seq_run_monitor.sv
// Run statistics for the sequence detector output: counts runs of z_i high, measures
// their length, tracks the longest, and offers each completed length over a 1-deep slot.
module seq_run_monitor #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_i,
    input  logic             clr_i,
    input  logic             run_ready_i,
    output logic             run_valid_o,
    output logic [LEN_W-1:0] run_len_o,
    output logic [LEN_W-1:0] run_max_o,
    output logic [CNT_W-1:0] evt_cnt_o,
    output logic             ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SKIP
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [LEN_W-1:0]   run_len_q;
    logic [LEN_W-1:0]   run_max_q;
    logic [CNT_W-1:0]   evt_cnt_q;
    logic [CNT_W-1:0]   evt_cnt_d;
    logic               run_valid_q;
    logic               ovf_q;
    logic               slot_free;

    // Saturating increments and slot availability (free if empty or being read now).
    always_comb begin
        len_d     = (len_q == '1) ? len_q : len_q + LEN_W'(1);
        evt_cnt_d = (evt_cnt_q == '1) ? evt_cnt_q : evt_cnt_q + CNT_W'(1);
        slot_free = !run_valid_q || run_ready_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKIP;
            len_q       <= '0;
            run_len_q   <= '0;
            run_max_q   <= '0;
            evt_cnt_q   <= '0;
            run_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clr_i) begin
            state_q     <= SKIP;
            len_q       <= '0;
            run_len_q   <= '0;
            run_max_q   <= '0;
            evt_cnt_q   <= '0;
            run_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (run_valid_q && run_ready_i) begin
                run_valid_q <= 1'b0;
            end
            unique case (state_q)
                SKIP: begin
                    if (!z_i) state_q <= IDLE;
                end
                IDLE: begin
                    if (z_i) begin
                        state_q   <= RUN;
                        len_q     <= LEN_W'(1);
                        evt_cnt_q <= evt_cnt_d;
                    end
                end
                RUN: begin
                    if (z_i) begin
                        len_q <= len_d;
                    end else begin
                        state_q <= IDLE;
                        if (len_q > run_max_q) run_max_q <= len_q;
                        // A load here overrides the consume-clear above on the same edge.
                        if (slot_free) begin
                            run_len_q   <= len_q;
                            run_valid_q <= 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= SKIP;
            endcase
        end
    end

    assign run_valid_o = run_valid_q;
    assign run_len_o   = run_len_q;
    assign run_max_o   = run_max_q;
    assign evt_cnt_o   = evt_cnt_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = (state_q == RUN);

endmodule
